// File: rtl/rgb_pwm_pkg.sv
// Shared types and wr_data field layout for the RGB PWM LED bank.
// wr_data layout, from MSB to LSB: {mode[1:0], r, g, b}, with b in the LSBs.
package rgb_pwm_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_ALT   = 2'd3
  } mode_t;

  localparam int MODE_W = 2;

  function automatic int b_lsb(input int pwm_bits);
    return 0 * pwm_bits;
  endfunction

  function automatic int g_lsb(input int pwm_bits);
    return pwm_bits;
  endfunction

  function automatic int r_lsb(input int pwm_bits);
    return 2 * pwm_bits;
  endfunction

  function automatic int mode_lsb(input int pwm_bits);
    return 3 * pwm_bits;
  endfunction

  function automatic int cfg_width(input int pwm_bits);
    return 3 * pwm_bits + MODE_W;
  endfunction

endpackage

// File: rtl/rgb_pwm_bank_if.sv
// Bus between the core's MMIO and the LED bank.
// master: drives the write port and observes the LED pins.
// slave : the LED bank, which takes writes and drives led_r/led_g/led_b/heartbeat.
interface rgb_pwm_bank_if
  import rgb_pwm_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int PWM_BITS = 8
);
  localparam int ADDR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DATA_W = cfg_width(PWM_BITS);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [NUM_CH-1:0] led_r;
  logic [NUM_CH-1:0] led_g;
  logic [NUM_CH-1:0] led_b;
  logic              heartbeat;

  modport master (
    output wr_en, wr_addr, wr_data,
    input  led_r, led_g, led_b, heartbeat
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    output led_r, led_g, led_b, heartbeat
  );
endinterface

// File: rtl/rgb_pwm_bank_channel.sv
// One RGB channel of the LED bank. It holds a shadow config and an active config,
// commits shadow to active at the PWM period boundary, and drives three registered
// PWM comparators.
// Ports: clk, reset (async, active-high), wr_hit_i (write aimed at this channel),
//        wr_data_i (new config), boundary_i (last tick of the period),
//        pwm_cnt_i (shared PWM counter), blink_i (free-running blink bit),
//        led_r_o/led_g_o/led_b_o (registered PWM outputs).
module pwm_channel
  import rgb_pwm_pkg::*;
#(
  parameter int PWM_BITS = 8,
  parameter int DATA_W   = 3 * PWM_BITS + 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_hit_i,
  input  logic [DATA_W-1:0]   wr_data_i,
  input  logic                boundary_i,
  input  logic [PWM_BITS-1:0] pwm_cnt_i,
  input  logic                blink_i,
  output logic                led_r_o,
  output logic                led_g_o,
  output logic                led_b_o
);

  typedef struct packed {
    mode_t               mode;
    logic [PWM_BITS-1:0] r;
    logic [PWM_BITS-1:0] g;
    logic [PWM_BITS-1:0] b;
  } chan_cfg_t;

  chan_cfg_t cfg_in;
  chan_cfg_t shadow_q, shadow_d;
  chan_cfg_t active_q, active_d;
  logic      gate;
  logic      led_r_q, led_g_q, led_b_q;

  assign cfg_in = chan_cfg_t'(wr_data_i);

  // A write landing in the boundary cycle is forwarded straight to active.
  // Otherwise it would sit in shadow for a whole extra period.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (wr_hit_i) shadow_d = cfg_in;
    if (boundary_i) active_d = wr_hit_i ? cfg_in : shadow_q;
  end

  always_comb begin
    gate = 1'b0;
    case (active_q.mode)
      MODE_OFF:   gate = 1'b0;
      MODE_ON:    gate = 1'b1;
      MODE_BLINK: gate = blink_i;
      MODE_ALT:   gate = ~blink_i;
      default:    gate = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q <= '0;
      active_q <= '0;
      led_r_q  <= 1'b0;
      led_g_q  <= 1'b0;
      led_b_q  <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      led_r_q  <= gate && (active_q.r > pwm_cnt_i);
      led_g_q  <= gate && (active_q.g > pwm_cnt_i);
      led_b_q  <= gate && (active_q.b > pwm_cnt_i);
    end
  end

  assign led_r_o = led_r_q;
  assign led_g_o = led_g_q;
  assign led_b_o = led_b_q;

endmodule

// File: rtl/rgb_pwm_bank.sv
// Board LED driver with NUM_CH RGB channels. Each colour has its own PWM duty.
// Each channel has an OFF/ON/BLINK/ALT mode.
// The prescaler, PWM counter and free-running blink counter are shared by all
// channels. Each channel lives in a pwm_channel instance.
// Ports: clk, reset (async, active-high), bus (rgb_pwm_bank_if.slave).
// The bus carries wr_en, wr_addr and wr_data in, and led_r, led_g, led_b and heartbeat out.
module rgb_pwm_bank
  import rgb_pwm_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int PWM_BITS  = 8,
  parameter int PRESCALE  = 64,
  parameter int BLINK_BIT = 22
) (
  input  logic          clk,
  input  logic          reset,
  rgb_pwm_bank_if.slave bus
);

  localparam int PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int ADDR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DATA_W = cfg_width(PWM_BITS);
  localparam logic [PS_W-1:0]   PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [ADDR_W:0]   CH_LIMIT = (ADDR_W + 1)'(NUM_CH);

  logic [PS_W-1:0]     presc_q, presc_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [BLINK_BIT:0]  free_cnt_q, free_cnt_d;
  logic                heartbeat_q;
  logic                tick;
  logic                boundary;
  logic                addr_ok;
  logic [NUM_CH-1:0]   led_r, led_g, led_b;

  // With PRESCALE=1 the prescaler stays at 0, which equals PS_LAST, so tick is constant 1.
  assign tick     = (presc_q == PS_LAST);
  assign boundary = tick && (pwm_cnt_q == '1);
  assign addr_ok  = ({1'b0, bus.wr_addr} < CH_LIMIT);

  always_comb begin
    presc_d    = tick ? '0 : presc_q + PS_W'(1);
    pwm_cnt_d  = tick ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;
    free_cnt_d = free_cnt_q + (BLINK_BIT + 1)'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q     <= '0;
      pwm_cnt_q   <= '0;
      free_cnt_q  <= '0;
      heartbeat_q <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      pwm_cnt_q   <= pwm_cnt_d;
      free_cnt_q  <= free_cnt_d;
      heartbeat_q <= free_cnt_q[BLINK_BIT];
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic wr_hit;
    assign wr_hit = bus.wr_en && addr_ok && (bus.wr_addr == ADDR_W'(gi));

    pwm_channel #(
      .PWM_BITS (PWM_BITS),
      .DATA_W   (DATA_W)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .wr_hit_i   (wr_hit),
      .wr_data_i  (bus.wr_data),
      .boundary_i (boundary),
      .pwm_cnt_i  (pwm_cnt_q),
      .blink_i    (free_cnt_q[BLINK_BIT]),
      .led_r_o    (led_r[gi]),
      .led_g_o    (led_g[gi]),
      .led_b_o    (led_b[gi])
    );
  end

  assign bus.led_r     = led_r;
  assign bus.led_g     = led_g;
  assign bus.led_b     = led_b;
  assign bus.heartbeat = heartbeat_q;

endmodule
